// File: rtl/audio_pkg.sv
// Shared audio definitions used by both the ADC receive and DAC transmit paths.
package audio_pkg;

    localparam int AUDIO_WIDTH = 16;

    typedef logic [AUDIO_WIDTH-1:0] sample_t;

endpackage

// File: rtl/lrck_edge_detect.sv
// Registers the codec LR clock on BCLK and flags its falling and rising edges.
module lrck_edge_detect (
    input  logic i_BCLK,
    input  logic i_rst_n,
    input  logic i_lrck,
    output logic o_fall,
    output logic o_rise
);

    logic pre_lrck_q;

    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_lrck_q <= 1'b0;
        end else begin
            pre_lrck_q <= i_lrck;
        end
    end

    assign o_fall = pre_lrck_q & ~i_lrck;
    assign o_rise = ~pre_lrck_q & i_lrck;

endmodule

// File: rtl/adc_receiver.sv
// I2S receive controller: deserialises left/right samples from ADCDAT and hands
// each complete frame downstream through a single-entry valid/ready register.
module adc_receiver
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH
) (
    input  logic             i_BCLK,
    input  logic             i_rst_n,
    input  logic             i_record,
    input  logic             i_ADCLRCK,
    input  logic             i_ADCDAT,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_left,
    output logic [WIDTH-1:0] o_right,
    output logic             o_overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ_LEFT,
        S_WAIT_RIGHT,
        S_READ_RIGHT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   left_sr_q, left_sr_d;
    logic [WIDTH-1:0]   right_sr_q, right_sr_d;
    logic [WIDTH-1:0]   hold_left_q, hold_left_d;
    logic [WIDTH-1:0]   hold_right_q, hold_right_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    logic fall, rise, last_bit;
    logic shift_left, shift_right, clr_cnt, frame_done, load;

    lrck_edge_detect u_edge (
        .i_BCLK  (i_BCLK),
        .i_rst_n (i_rst_n),
        .i_lrck  (i_ADCLRCK),
        .o_fall  (fall),
        .o_rise  (rise)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_record) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:       state_d = S_WAIT;
                S_WAIT:       if (fall) state_d = S_READ_LEFT;
                // A rise before the left word is complete means a short channel: drop it.
                S_READ_LEFT: begin
                    if (fall)          state_d = S_READ_LEFT;
                    else if (rise)     state_d = S_WAIT;
                    else if (last_bit) state_d = S_WAIT_RIGHT;
                end
                S_WAIT_RIGHT: begin
                    if (fall)      state_d = S_READ_LEFT;
                    else if (rise) state_d = S_READ_RIGHT;
                end
                S_READ_RIGHT: begin
                    if (fall)          state_d = S_READ_LEFT;
                    else if (last_bit) state_d = S_WAIT;
                end
                default:      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_left  = i_record && (state_q == S_READ_LEFT) && !fall && !rise;
        shift_right = i_record && (state_q == S_READ_RIGHT) && !fall;
        clr_cnt     = i_record && ((fall && state_q != S_IDLE) ||
                                   (rise && state_q == S_WAIT_RIGHT));
        frame_done  = shift_right && last_bit;
    end

    // Holding register accepts a new frame only if it is empty or being drained this edge.
    always_comb begin
        cnt_d        = cnt_q;
        left_sr_d    = left_sr_q;
        right_sr_d   = right_sr_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        load         = frame_done && (!valid_q || i_ready);

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (shift_left || shift_right) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (shift_left) begin
            left_sr_d = (left_sr_q << 1) | WIDTH'(i_ADCDAT);
        end
        if (shift_right) begin
            right_sr_d = (right_sr_q << 1) | WIDTH'(i_ADCDAT);
        end

        if (load) begin
            hold_left_d  = left_sr_q;
            hold_right_d = right_sr_d;
            valid_d      = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (frame_done && valid_q && !i_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            left_sr_q    <= '0;
            right_sr_q   <= '0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            left_sr_q    <= left_sr_d;
            right_sr_q   <= right_sr_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_left    = hold_left_q;
    assign o_right   = hold_right_q;
    assign o_overrun = overrun_q;

endmodule
